// File: rtl/tank_encoder2_r1_up.sv
// r1 "up" tank encoder: arbitrates per-tank in/out requests and holds the dual-rail
// f7/f8 + t_in/t_out encoding for HOLD_MC minor cycles. Macro TANK_ENC_ROUND_ROBIN_EN selects round-robin arbitration.
module tank_encoder2_r1_up #(
    parameter int HOLD_MC = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic minor_cycle_start,
    input  logic req_t0_in,
    input  logic req_t0_out,
    input  logic req_t1_in,
    input  logic req_t1_out,
    input  logic req_t2_in,
    input  logic req_t2_out,
    input  logic req_t3_in,
    input  logic req_t3_out,
    output logic r1_up_f7_pos,
    output logic r1_up_f7_neg,
    output logic r1_up_f8_pos,
    output logic r1_up_f8_neg,
    output logic r1_up_t_in,
    output logic r1_up_t_out,
    output logic busy,
    output logic ack,
    output logic err_multi
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_DRIVE,
        S_ACK
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_EFF = (HOLD_MC == 0) ? CNT_W'(1) : CNT_W'(HOLD_MC);

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_multi_q, err_multi_d;
    logic [7:0]       req;
    logic [2:0]       pick;
    logic             multi;
    logic             drive;

    // Request index: bit 0 = direction (0 in, 1 out), bits 2:1 = tank number.
    assign req   = {req_t3_out, req_t3_in, req_t2_out, req_t2_in,
                    req_t1_out, req_t1_in, req_t0_out, req_t0_in};
    assign multi = |(req & (req - 8'd1));

`ifdef TANK_ENC_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx;
    logic       found;

    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_ACK) ptr_d = grant_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 3'd0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        pick = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) pick = 3'(i);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        err_multi_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d     = pick;
                    err_multi_d = multi;
                    state_d     = S_ALIGN;
                end
            end
            // The capture-cycle pulse is never seen here; alignment needs a later one.
            S_ALIGN: begin
                if (minor_cycle_start) begin
                    cnt_d   = HOLD_EFF;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (minor_cycle_start) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= 3'd0;
            cnt_q       <= '0;
            err_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            err_multi_q <= err_multi_d;
        end
    end

    assign drive        = (state_q == S_DRIVE);
    assign r1_up_f7_pos = drive &  grant_q[1];
    assign r1_up_f7_neg = drive & ~grant_q[1];
    assign r1_up_f8_pos = drive &  grant_q[2];
    assign r1_up_f8_neg = drive & ~grant_q[2];
    assign r1_up_t_in   = drive & ~grant_q[0];
    assign r1_up_t_out  = drive &  grant_q[0];
    assign busy         = (state_q != S_IDLE);
    assign ack          = (state_q == S_ACK);
    assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_tank_encoder2_r1_up.sv
// Directed bench for tank_encoder2_r1_up: one instance with HOLD_MC=1, one with HOLD_MC=3.
module tb_tank_encoder2_r1_up;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mcs;
    logic [7:0] req1, req3;

    logic f7p1, f7n1, f8p1, f8n1, tin1, tout1, busy1, ack1, err1;
    logic f7p3, f7n3, f8p3, f8n3, tin3, tout3, busy3, ack3, err3;
    logic [5:0] lines1, lines3;

    int n_vec = 0;
    int n_err = 0;
    int w;

    assign lines1 = {f7p1, f7n1, f8p1, f8n1, tin1, tout1};
    assign lines3 = {f7p3, f7n3, f8p3, f8n3, tin3, tout3};

    always #5 clk = ~clk;

    tank_encoder2_r1_up #(.HOLD_MC(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .minor_cycle_start(mcs),
        .req_t0_in(req1[0]), .req_t0_out(req1[1]), .req_t1_in(req1[2]), .req_t1_out(req1[3]),
        .req_t2_in(req1[4]), .req_t2_out(req1[5]), .req_t3_in(req1[6]), .req_t3_out(req1[7]),
        .r1_up_f7_pos(f7p1), .r1_up_f7_neg(f7n1), .r1_up_f8_pos(f8p1), .r1_up_f8_neg(f8n1),
        .r1_up_t_in(tin1), .r1_up_t_out(tout1), .busy(busy1), .ack(ack1), .err_multi(err1)
    );

    tank_encoder2_r1_up #(.HOLD_MC(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .minor_cycle_start(mcs),
        .req_t0_in(req3[0]), .req_t0_out(req3[1]), .req_t1_in(req3[2]), .req_t1_out(req3[3]),
        .req_t2_in(req3[4]), .req_t2_out(req3[5]), .req_t3_in(req3[6]), .req_t3_out(req3[7]),
        .r1_up_f7_pos(f7p3), .r1_up_f7_neg(f7n3), .r1_up_f8_pos(f8p3), .r1_up_f8_neg(f8n3),
        .r1_up_t_in(tin3), .r1_up_t_out(tout3), .busy(busy3), .ack(ack3), .err_multi(err3)
    );

    // Minor-cycle pulse: one clk high every 16 clks, changed on the falling edge.
    initial begin
        mcs = 1'b0;
        forever begin
            repeat (15) @(negedge clk);
            mcs = 1'b1;
            @(negedge clk);
            mcs = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] cur_lines(input bit s);
        return s ? lines3 : lines1;
    endfunction

    // Waits for DRIVE, checks line values, drive length and a single-cycle ack,
    // then drops the requester's bits as the requester would after ack.
    task automatic observe(input bit sel3, input logic [5:0] exp, input int exp_len,
                           input logic [7:0] drop, input string tag, output int waited);
        int  k;
        int  len;
        bit  stable;
        k = 0;
        while (k < 200 && cur_lines(sel3) == 6'd0) begin
            @(negedge clk);
            k++;
        end
        waited = k;
        chk({tag, "_lines"}, 32'(cur_lines(sel3)), 32'(exp));
        len    = 0;
        stable = 1'b1;
        while (len < 200 && cur_lines(sel3) != 6'd0) begin
            if (cur_lines(sel3) !== exp) stable = 1'b0;
            len++;
            @(negedge clk);
        end
        chk({tag, "_len"}, 32'(len), 32'(exp_len));
        chk({tag, "_stable"}, 32'(stable), 32'd1);
        chk({tag, "_ack"}, 32'(sel3 ? ack3 : ack1), 32'd1);
        if (sel3) req3 = req3 & ~drop;
        else      req1 = req1 & ~drop;
        @(negedge clk);
        chk({tag, "_ack_width"}, 32'(sel3 ? ack3 : ack1), 32'd0);
        chk({tag, "_idle"}, 32'(sel3 ? busy3 : busy1), 32'd0);
    endtask

    initial begin
        int  k;
        bit  bad;
        rst_n = 1'b0;
        req1  = 8'h00;
        req3  = 8'h00;
        #1;
        chk("reset_outs1", {23'd0, lines1, busy1, ack1, err1}, 32'd0);
        chk("reset_outs3", {23'd0, lines3, busy3, ack3, err3}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, HOLD_MC=1: tank 2 in.
        req1 = 8'h10;
        @(negedge clk);
        chk("single_err", 32'(err1), 32'd0);
        observe(1'b0, 6'b011010, 16, 8'h10, "t2_in", w);

        // HOLD_MC=3: tank 3 out held for three minor cycles.
        req3 = 8'h80;
        observe(1'b1, 6'b101001, 48, 8'h80, "t3_out_h3", w);

        // Request rising with the pulse must wait for the following pulse.
        wait (mcs == 1'b0);
        wait (mcs == 1'b1);
        req1 = 8'h08;
        observe(1'b0, 6'b100101, 16, 8'h08, "coinc_t1_out", w);
        chk("coinc_latency", 32'(w), 32'd17);

        // Two requests: err_multi pulse, t0_out first, then t1_in back-to-back.
        @(negedge clk);
        req1 = 8'h06;
        @(negedge clk);
        chk("multi_err_pulse", 32'(err1), 32'd1);
        @(negedge clk);
        chk("multi_err_width", 32'(err1), 32'd0);
        observe(1'b0, 6'b010101, 16, 8'h02, "multi_t0_out", w);
        observe(1'b0, 6'b100110, 16, 8'h04, "b2b_t1_in", w);

        // After a t0_out grant, {t0_in, t1_in}: fixed priority picks t0_in, round-robin t1_in.
        req1 = 8'h02;
        observe(1'b0, 6'b010101, 16, 8'h02, "arb_t0_out", w);
        req1 = 8'h05;
`ifdef TANK_ENC_ROUND_ROBIN_EN
        observe(1'b0, 6'b100110, 16, 8'h04, "arb_first_t1_in", w);
        observe(1'b0, 6'b010110, 16, 8'h01, "arb_second_t0_in", w);
`else
        observe(1'b0, 6'b010110, 16, 8'h01, "arb_first_t0_in", w);
        observe(1'b0, 6'b100110, 16, 8'h04, "arb_second_t1_in", w);
`endif

        // Reset mid-DRIVE on tank 2 out aborts with no ack.
        req1 = 8'h20;
        k = 0;
        while (k < 100 && lines1 == 6'd0) begin
            @(negedge clk);
            k++;
        end
        chk("rst_pre_lines", 32'(lines1), 32'b011001);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {23'd0, lines1, busy1, ack1, err1}, 32'd0);
        req1 = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_held_ack", 32'(ack1), 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy1 !== 1'b0 || ack1 !== 1'b0) bad = 1'b1;
        end
        chk("rst_release_idle", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
